// File: rtl/uart_tx_frame_if.sv
// Host-side transmit handshake: one byte plus its frame configuration,
// transferred on tx_valid & tx_ready.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 stop2;

    modport master (
        output tx_data, tx_valid, parity_en, parity_odd, stop2,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, parity_en, parity_odd, stop2,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Every line transition is aligned to a baud tick from the external generator.
module uart_tx_frame #(
    parameter int DATA_BITS = 8
) (
    input  logic           clk26m,
    input  logic           rst26m,
    uart_tx_frame_if.slave host,
    input  logic           tx_bpsclk,
    output logic           tx_bps_en,
    output logic           txd,
    output logic           tx_busy,
    output logic           tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_e;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 par_acc_q, par_acc_d;
    logic                 par_en_q, par_en_d;
    logic                 stop2_q, stop2_d;
    logic                 txd_q, txd_d;
    logic                 bps_en_q, bps_en_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic tick;
    logic accept;
    logic last_bit;
    logic finish;

    // A generator pulse only counts while this side has its counter enabled.
    assign tick     = tx_bpsclk & bps_en_q;
    assign accept   = host.tx_valid & ready_q;
    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign finish   = tick & (((state_q == S_STOP1) & ~stop2_q) | (state_q == S_STOP2));

    always_ff @(posedge clk26m) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst26m) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_acc_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            txd_q     <= 1'b1;
            bps_en_q  <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_acc_q <= par_acc_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            txd_q     <= txd_d;
            bps_en_q  <= bps_en_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold-value default before the case so that
        // no path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_acc_d = par_acc_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d   = host.tx_data;
                    par_acc_d = host.parity_odd;
                    par_en_d  = host.parity_en;
                    stop2_d   = host.stop2;
                    state_d   = S_LEAD;
                end
            end
            S_LEAD: begin
                if (tick) state_d = S_START;
            end
            S_START: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    par_acc_d = par_acc_q ^ shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (!last_bit) begin
                        shift_d   = shift_q >> 1;
                        par_acc_d = par_acc_q ^ shift_q[0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (par_en_q) begin
                        state_d = S_PARITY;
                    end else begin
                        state_d = S_STOP1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) state_d = S_STOP1;
            end
            S_STOP1: begin
                if (tick) state_d = stop2_q ? S_STOP2 : S_IDLE;
            end
            S_STOP2: begin
                if (tick) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs: next values for the line and the handshake flags.
    always_comb begin
        txd_d    = txd_q;
        bps_en_d = bps_en_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (accept) begin
            txd_d    = 1'b1;
            bps_en_d = 1'b1;
            ready_d  = 1'b0;
            busy_d   = 1'b1;
        end

        unique case (state_q)
            S_LEAD:   if (tick) txd_d = 1'b0;
            S_START:  if (tick) txd_d = shift_q[0];
            S_DATA: begin
                if (tick) begin
                    if (!last_bit)     txd_d = shift_q[0];
                    else if (par_en_q) txd_d = par_acc_q;
                    else               txd_d = 1'b1;
                end
            end
            S_PARITY: if (tick) txd_d = 1'b1;
            default:  ;
        endcase

        // The final stop tick closes the frame and frees the host side.
        if (finish) begin
            txd_d    = 1'b1;
            done_d   = 1'b1;
            bps_en_d = 1'b0;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
        end
    end

    assign host.tx_ready = ready_q;
    assign tx_bps_en     = bps_en_q;
    assign txd           = txd_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;

    a_ready_not_busy: assert property (@(posedge clk26m) disable iff (rst26m)
        !(ready_q && busy_q));

    a_done_single: assert property (@(posedge clk26m) disable iff (rst26m)
        done_q |=> !done_q);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomised and directed bench for uart_tx_frame, checked every cycle against a
// frame-level model that treats each frame as a list of bits advanced per tick.
module tb_uart_tx_frame;

    localparam int PER  = 17;
    localparam int HALF = 8;

    logic clk26m = 1'b0;
    logic rst26m;
    logic tx_bpsclk, tx_bps_en, txd, tx_busy, tx_done;
    logic tx_bpsclk5, tx_bps_en5, txd5, tx_busy5, tx_done5;

    always #5 clk26m = ~clk26m;

    uart_tx_frame_if #(.DATA_BITS(8)) host_if ();
    uart_tx_frame_if #(.DATA_BITS(5)) host5_if ();

    uart_tx_frame #(.DATA_BITS(8)) u_dut (
        .clk26m    (clk26m),
        .rst26m    (rst26m),
        .host      (host_if),
        .tx_bpsclk (tx_bpsclk),
        .tx_bps_en (tx_bps_en),
        .txd       (txd),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    uart_tx_frame #(.DATA_BITS(5)) u_dut5 (
        .clk26m    (clk26m),
        .rst26m    (rst26m),
        .host      (host5_if),
        .tx_bpsclk (tx_bpsclk5),
        .tx_bps_en (tx_bps_en5),
        .txd       (txd5),
        .tx_busy   (tx_busy5),
        .tx_done   (tx_done5)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;
    int mode   = 0;   // 0: baud generator, 1: random ticks, 2: tick stuck high
    int gen_cnt = 0;
    int cyc = 0;

    // Frame-level model state.
    bit m_txd = 1'b1, m_en = 1'b0, m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    bit m_active = 1'b0;
    bit m_frame [16];
    int m_pos = 0, m_len = 0;
    int n_accepts = 0;

    // Line recorders: the bit held on the line just before each tick.
    bit   line_q [$];
    int   tick_q [$];
    bit   line5_q [$];
    logic prev_txd = 1'b1, prev_en = 1'b0, prev_txd5 = 1'b1, prev_en5 = 1'b0;
    int   n_done = 0, n_done5 = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk26m) cyc <= cyc + 1;

    always @(negedge clk26m) begin
        if (chk_on) begin
            check("txd",       16'(txd),              16'(m_txd));
            check("tx_bps_en", 16'(tx_bps_en),        16'(m_en));
            check("tx_ready",  16'(host_if.tx_ready), 16'(m_ready));
            check("tx_busy",   16'(tx_busy),          16'(m_busy));
            check("tx_done",   16'(tx_done),          16'(m_done));
            check("ready_and_busy", 16'(host_if.tx_ready & tx_busy), 16'd0);
        end
        if (tx_bpsclk === 1'b1 && prev_en === 1'b1) begin
            line_q.push_back(prev_txd);
            tick_q.push_back(cyc);
        end
        if (tx_bpsclk5 === 1'b1 && prev_en5 === 1'b1) line5_q.push_back(prev_txd5);
        if (tx_done === 1'b1)  n_done  <= n_done + 1;
        if (tx_done5 === 1'b1) n_done5 <= n_done5 + 1;
        prev_txd  <= txd;
        prev_en   <= tx_bps_en;
        prev_txd5 <= txd5;
        prev_en5  <= tx_bps_en5;
    end

    task automatic model_step();
        bit         tick;
        logic [7:0] d;
        tick = tx_bpsclk && m_en;
        if (rst26m) begin
            m_txd = 1'b1; m_en = 1'b0; m_ready = 1'b1; m_busy = 1'b0;
            m_done = 1'b0; m_active = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (host_if.tx_valid && m_ready) begin
                    d = host_if.tx_data;
                    m_frame[0] = 1'b0;
                    for (int i = 0; i < 8; i++) m_frame[1 + i] = d[i];
                    m_len = 9;
                    if (host_if.parity_en) begin
                        m_frame[m_len] = (^d) ^ host_if.parity_odd;
                        m_len++;
                    end
                    m_frame[m_len] = 1'b1;
                    m_len++;
                    if (host_if.stop2) begin
                        m_frame[m_len] = 1'b1;
                        m_len++;
                    end
                    n_accepts++;
                    m_active = 1'b1; m_pos = -1;
                    m_en = 1'b1; m_ready = 1'b0; m_busy = 1'b1; m_txd = 1'b1;
                end
            end else if (tick) begin
                m_pos++;
                if (m_pos == m_len) begin
                    m_done = 1'b1; m_en = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
                    m_active = 1'b0; m_txd = 1'b1;
                end else begin
                    m_txd = m_frame[m_pos];
                end
            end
        end
    endtask

    task automatic drive_env();
        case (mode)
            0: begin
                if (tx_bps_en !== 1'b1) gen_cnt = 0;
                else                    gen_cnt = (gen_cnt == PER - 1) ? 0 : gen_cnt + 1;
                tx_bpsclk = (tx_bps_en === 1'b1) && (gen_cnt == HALF);
            end
            1:       tx_bpsclk = ($urandom_range(0, 2) == 0);
            default: tx_bpsclk = 1'b1;
        endcase
        tx_bpsclk5 = (tx_bps_en5 === 1'b1) && ($urandom_range(0, 1) == 1);
    endtask

    task automatic step();
        @(posedge clk26m);
        model_step();
        @(negedge clk26m);
        #1;
        drive_env();
    endtask

    task automatic randomize_host_payload();
        host_if.tx_valid   = ($urandom_range(0, 1) == 1);
        host_if.tx_data    = 8'($urandom);
        host_if.parity_en  = 1'($urandom);
        host_if.parity_odd = 1'($urandom);
        host_if.stop2      = 1'($urandom);
    endtask

    task automatic finish_frame(input int start, input int d0, input logic [15:0] exp_v,
                                input int exp_n, input string name);
        bit          seen;
        logic [15:0] v;
        int          mn, mx, g;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (n_done != d0) begin
                seen = 1'b1;
                break;
            end
            randomize_host_payload();
            step();
        end
        host_if.tx_valid = 1'b0;
        check({name, "_done_seen"}, 16'(seen), 16'd1);
        v = '0;
        for (int i = start; i < line_q.size(); i++) v = {v[14:0], line_q[i]};
        check({name, "_bits"}, v, exp_v);
        check({name, "_ticks"}, 16'(line_q.size() - start), 16'(exp_n));
        if (mode == 0 && line_q.size() > start + 1) begin
            mn = 1 << 30;
            mx = 0;
            for (int i = start + 1; i < tick_q.size(); i++) begin
                g  = tick_q[i] - tick_q[i - 1];
                mn = (g < mn) ? g : mn;
                mx = (g > mx) ? g : mx;
            end
            check({name, "_period_min"}, 16'(mn), 16'(PER));
            check({name, "_period_max"}, 16'(mx), 16'(PER));
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pe, input bit po, input bit s2,
                              input logic [15:0] exp_v, input int exp_n, input string name);
        int start, d0;
        start = line_q.size();
        d0    = n_done;
        host_if.tx_valid   = 1'b1;
        host_if.tx_data    = d;
        host_if.parity_en  = pe;
        host_if.parity_odd = po;
        host_if.stop2      = s2;
        step();
        host_if.tx_valid = 1'b0;
        finish_frame(start, d0, exp_v, exp_n, name);
    endtask

    task automatic send_frame5(input logic [4:0] d, input bit pe, input bit po, input bit s2,
                               input logic [15:0] exp_v, input int exp_n, input string name);
        int          start, d0;
        bit          seen;
        logic [15:0] v;
        start = line5_q.size();
        d0    = n_done5;
        host5_if.tx_valid   = 1'b1;
        host5_if.tx_data    = d;
        host5_if.parity_en  = pe;
        host5_if.parity_odd = po;
        host5_if.stop2      = s2;
        step();
        host5_if.tx_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (n_done5 != d0) begin
                seen = 1'b1;
                break;
            end
            host5_if.tx_data = 5'($urandom);
            host5_if.stop2   = 1'($urandom);
            step();
        end
        check({name, "_done_seen"}, 16'(seen), 16'd1);
        v = '0;
        for (int i = start; i < line5_q.size(); i++) v = {v[14:0], line5_q[i]};
        check({name, "_bits"}, v, exp_v);
        check({name, "_ticks"}, 16'(line5_q.size() - start), 16'(exp_n));
    endtask

    initial begin
        int          start, d0, a0, k;
        bit          flag;
        logic [7:0]  bytes [3];

        rst26m              = 1'b1;
        tx_bpsclk           = 1'b0;
        tx_bpsclk5          = 1'b0;
        host_if.tx_valid    = 1'b1;
        host_if.tx_data     = 8'hA5;
        host_if.parity_en   = 1'b0;
        host_if.parity_odd  = 1'b0;
        host_if.stop2       = 1'b0;
        host5_if.tx_valid   = 1'b0;
        host5_if.tx_data    = '0;
        host5_if.parity_en  = 1'b0;
        host5_if.parity_odd = 1'b0;
        host5_if.stop2      = 1'b0;
        chk_on              = 1'b1;

        // Reset with tx_valid already high; the byte must be taken right after release.
        repeat (3) step();
        check("rst_txd",   16'(txd),              16'd1);
        check("rst_bps",   16'(tx_bps_en),        16'd0);
        check("rst_ready", 16'(host_if.tx_ready), 16'd1);
        check("rst_busy",  16'(tx_busy),          16'd0);
        check("rst_done",  16'(tx_done),          16'd0);
        start  = line_q.size();
        d0     = n_done;
        rst26m = 1'b0;
        step();
        check("accept_after_reset_busy",  16'(tx_busy),          16'd1);
        check("accept_after_reset_ready", 16'(host_if.tx_ready), 16'd0);
        host_if.tx_valid = 1'b0;
        finish_frame(start, d0, 16'b101_0100_1011, 11, "basic_a5");
        step();
        check("bps_en_after_frame", 16'(tx_bps_en), 16'd0);

        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 16'b1011_0000_0001, 12, "par_03_even");
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 16'b1011_0000_0011, 12, "par_03_odd");
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 16'b1011_1000_0011, 12, "par_07_even");
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 16'b1011_1111_1111, 12, "stop2_ff");

        // Abort a frame during data bit 3, then the next frame must be clean.
        d0 = n_done;
        host_if.tx_valid = 1'b1;
        host_if.tx_data  = 8'hC3;
        step();
        host_if.tx_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_active && m_pos == 4) break;
            step();
        end
        check("abort_reached_bit3", 16'(m_pos), 16'd4);
        repeat (5) step();
        rst26m = 1'b1;
        step();
        rst26m = 1'b0;
        check("abort_txd",   16'(txd),              16'd1);
        check("abort_bps",   16'(tx_bps_en),        16'd0);
        check("abort_ready", 16'(host_if.tx_ready), 16'd1);
        check("abort_done",  16'(tx_done),          16'd0);
        step();
        check("abort_no_done_pulse", 16'(n_done - d0), 16'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 16'b100_1011_0101, 11, "after_abort_5a");

        // Baud ticks while idle must not disturb the line.
        mode = 2;
        repeat (6) step();
        check("spurious_txd", 16'(txd),       16'd1);
        check("spurious_bps", 16'(tx_bps_en), 16'd0);
        mode = 0;
        step();

        // Back-to-back transfers with tx_valid held high.
        bytes[0] = 8'h11;
        bytes[1] = 8'h22;
        bytes[2] = 8'h33;
        a0 = n_accepts;
        d0 = n_done;
        k  = 0;
        host_if.parity_en = 1'b0;
        host_if.stop2     = 1'b0;
        host_if.tx_valid  = 1'b1;
        host_if.tx_data   = bytes[0];
        for (int i = 0; i < 3000; i++) begin
            flag = (n_accepts != a0 + k);
            if (flag) begin
                k++;
                if (k < 3) host_if.tx_data = bytes[k];
                else       host_if.tx_valid = 1'b0;
            end
            if (n_done - d0 >= 3) break;
            step();
        end
        host_if.tx_valid = 1'b0;
        check("b2b_accepts", 16'(n_accepts - a0), 16'd3);
        check("b2b_done",    16'(n_done - d0),    16'd3);

        // Random traffic, random tick pattern, occasional reset.
        mode = 1;
        for (int i = 0; i < 3000; i++) begin
            rst26m = ($urandom_range(0, 299) == 0);
            randomize_host_payload();
            step();
        end
        rst26m           = 1'b0;
        host_if.tx_valid = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!m_active) break;
            step();
        end
        check("random_drain", 16'(m_active), 16'd0);

        // Five-bit build: data counter must stop after five bits.
        send_frame5(5'h15, 1'b0, 1'b0, 1'b0, 16'b1010_1011, 8, "db5_15");
        send_frame5(5'h0A, 1'b1, 1'b1, 1'b1, 16'b10_0101_0111, 10, "db5_0a_odd_stop2");

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
